// File: rtl/jzjpcc_mem_access_unit.sv
// Memory stage: EX/MEM register, data-memory req/ready port, load align/extend, writeback register.
// Latency: capture -> request next cycle -> writeback valid the cycle after dmemReady (2 cycles minimum).
// Backpressure: memStall holds upstream while a request is outstanding; a watchdog aborts stuck requests.
module jzjpcc_mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_execute,
  input  logic        memRead_execute,
  input  logic        memWrite_execute,
  input  logic [2:0]  funct3_execute,
  input  logic [1:0]  byteOffset_execute,
  input  logic [29:0] memAddress_execute,
  input  logic [3:0]  memByteMask_execute,
  input  logic [31:0] memDataToWrite_execute,
  input  logic [4:0]  rdAddress_execute,
  output logic        memStall,
  output logic        dmemReq,
  output logic        dmemWriteEnable,
  output logic [29:0] dmemAddress,
  output logic [3:0]  dmemByteMask,
  output logic [31:0] dmemWriteData,
  input  logic        dmemReady,
  input  logic [31:0] dmemReadData,
  output logic [31:0] loadResult_writeback,
  output logic [4:0]  rdAddress_writeback,
  output logic        loadValid_writeback,
  output logic        misaligned,
  output logic        illegalAccess,
  output logic        busError
);

  localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t state, state_next;

  // EX/MEM register
  logic [29:0] exm_addr;
  logic [3:0]  exm_mask;
  logic [31:0] exm_wdata;
  logic        exm_read;
  logic        exm_write;
  logic [2:0]  exm_funct3;
  logic [1:0]  exm_offset;
  logic [4:0]  exm_rd;

  logic [15:0] wait_cnt;

  logic        capture;
  logic        bad_funct3;
  logic        bad_align;
  logic        access_ok;
  logic        complete;
  logic        abort;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  // Decode the incoming access: capture condition and the illegal/misaligned checks on raw execute inputs
  always_comb begin
    capture    = ~memStall & valid_execute & (memRead_execute | memWrite_execute);
    bad_funct3 = (funct3_execute == 3'b011) || (funct3_execute == 3'b110) ||
                 (funct3_execute == 3'b111) || (memWrite_execute && funct3_execute[2]);
    bad_align  = ((funct3_execute[1:0] == 2'b01) && byteOffset_execute[0]) ||
                 ((funct3_execute[1:0] == 2'b10) && (byteOffset_execute != 2'b00));
    // An undefined funct3 is reported as illegal even if its offset would also be misaligned
    access_ok  = capture & ~bad_funct3 & ~bad_align;
  end

  // Handshake events: completion on ready, abort once the counter has hit the limit with no ready
  always_comb begin
    complete = (state == REQ) & dmemReady;
    abort    = (state == REQ) & ~dmemReady & (wait_cnt == MAX_WAIT_C);
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic; a completing request may chain straight into the next one
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = access_ok ? REQ : IDLE;
      REQ: begin
        if (dmemReady)  state_next = access_ok ? REQ : IDLE;
        else if (abort) state_next = IDLE;
        else            state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: request straight from the state register, stall released combinationally by ready
  always_comb begin
    dmemReq         = (state == REQ);
    memStall        = (state == REQ) & ~dmemReady;
    dmemWriteEnable = (state == REQ) & exm_write;
    dmemAddress     = exm_addr;
    dmemByteMask    = exm_mask;
    dmemWriteData   = exm_wdata;
  end

  // EX/MEM register: loads on every capture, including rejected ones (they never raise a request)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exm_addr   <= '0;
      exm_mask   <= '0;
      exm_wdata  <= '0;
      exm_read   <= 1'b0;
      exm_write  <= 1'b0;
      exm_funct3 <= '0;
      exm_offset <= '0;
      exm_rd     <= '0;
    end else if (capture) begin
      exm_addr   <= memAddress_execute;
      exm_mask   <= memByteMask_execute;
      exm_wdata  <= memDataToWrite_execute;
      exm_read   <= memRead_execute;
      exm_write  <= memWrite_execute;
      exm_funct3 <= funct3_execute;
      exm_offset <= byteOffset_execute;
      exm_rd     <= rdAddress_execute;
    end
  end

  // Watchdog: counts stalled REQ cycles, cleared on completion, abort, or outside REQ
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                      wait_cnt <= '0;
    else if ((state == REQ) && !dmemReady && !abort) wait_cnt <= wait_cnt + 16'd1;
    else                                            wait_cnt <= '0;
  end

  // Load alignment and extension using the registered byte offset and funct3
  always_comb begin
    case (exm_offset)
      2'd0:    ld_byte = dmemReadData[7:0];
      2'd1:    ld_byte = dmemReadData[15:8];
      2'd2:    ld_byte = dmemReadData[23:16];
      default: ld_byte = dmemReadData[31:24];
    endcase
    ld_half = exm_offset[1] ? dmemReadData[31:16] : dmemReadData[15:0];
    case (exm_funct3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = dmemReadData;
    endcase
  end

  // Writeback register: valid only for the cycle after a load completes; data and rd hold otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loadResult_writeback <= '0;
      rdAddress_writeback  <= '0;
      loadValid_writeback  <= 1'b0;
    end else if (complete && exm_read && !exm_write) begin
      loadResult_writeback <= ld_value;
      rdAddress_writeback  <= exm_rd;
      loadValid_writeback  <= 1'b1;
    end else begin
      loadValid_writeback  <= 1'b0;
    end
  end

  // Single-cycle error pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      misaligned    <= 1'b0;
      illegalAccess <= 1'b0;
      busError      <= 1'b0;
    end else begin
      misaligned    <= capture & ~bad_funct3 & bad_align;
      illegalAccess <= capture & bad_funct3;
      busError      <= abort;
    end
  end

endmodule

// File: tb/tb_jzjpcc_mem_access_unit.sv
module tb_jzjpcc_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_execute;
  logic        memRead_execute;
  logic        memWrite_execute;
  logic [2:0]  funct3_execute;
  logic [1:0]  byteOffset_execute;
  logic [29:0] memAddress_execute;
  logic [3:0]  memByteMask_execute;
  logic [31:0] memDataToWrite_execute;
  logic [4:0]  rdAddress_execute;
  logic        memStall;
  logic        dmemReq;
  logic        dmemWriteEnable;
  logic [29:0] dmemAddress;
  logic [3:0]  dmemByteMask;
  logic [31:0] dmemWriteData;
  logic        dmemReady;
  logic [31:0] dmemReadData;
  logic [31:0] loadResult_writeback;
  logic [4:0]  rdAddress_writeback;
  logic        loadValid_writeback;
  logic        misaligned;
  logic        illegalAccess;
  logic        busError;

  int n_cmp = 0;
  int n_bad = 0;

  jzjpcc_mem_access_unit #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .valid_execute(valid_execute), .memRead_execute(memRead_execute),
    .memWrite_execute(memWrite_execute), .funct3_execute(funct3_execute),
    .byteOffset_execute(byteOffset_execute), .memAddress_execute(memAddress_execute),
    .memByteMask_execute(memByteMask_execute), .memDataToWrite_execute(memDataToWrite_execute),
    .rdAddress_execute(rdAddress_execute), .memStall(memStall), .dmemReq(dmemReq),
    .dmemWriteEnable(dmemWriteEnable), .dmemAddress(dmemAddress), .dmemByteMask(dmemByteMask),
    .dmemWriteData(dmemWriteData), .dmemReady(dmemReady), .dmemReadData(dmemReadData),
    .loadResult_writeback(loadResult_writeback), .rdAddress_writeback(rdAddress_writeback),
    .loadValid_writeback(loadValid_writeback), .misaligned(misaligned),
    .illegalAccess(illegalAccess), .busError(busError)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                     input logic [1:0] off, input logic [29:0] addr, input logic [3:0] mask,
                     input logic [31:0] wd, input logic [4:0] rd);
    valid_execute          = 1'b1;
    memRead_execute        = rd_en;
    memWrite_execute       = wr_en;
    funct3_execute         = f3;
    byteOffset_execute     = off;
    memAddress_execute     = addr;
    memByteMask_execute    = mask;
    memDataToWrite_execute = wd;
    rdAddress_execute      = rd;
  endtask

  task automatic idle_exec();
    valid_execute    = 1'b0;
    memRead_execute  = 1'b0;
    memWrite_execute = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [31:0] exp);
    put(1'b1, 1'b0, f3, off, 30'h10, 4'hF, 32'd0, 5'd9);
    dmemReady    = 1'b1;
    dmemReadData = rdata;
    step();
    idle_exec();
    #1;
    chk({tag, "_req"}, 32'(dmemReq), 32'd1);
    step();
    chk({tag, "_vld"}, 32'(loadValid_writeback), 32'd1);
    chk({tag, "_res"}, loadResult_writeback, exp);
  endtask

  task automatic reject(input string tag, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [1:0] off,
                        input logic exp_mis, input logic exp_ill);
    put(rd_en, wr_en, f3, off, 30'h33, 4'hF, 32'h0, 5'd3);
    dmemReady = 1'b0;
    step();
    idle_exec();
    #1;
    chk({tag, "_mis"}, 32'(misaligned), 32'(exp_mis));
    chk({tag, "_ill"}, 32'(illegalAccess), 32'(exp_ill));
    chk({tag, "_noreq"}, 32'(dmemReq), 32'd0);
    step();
    chk({tag, "_pulse_end"}, 32'(misaligned | illegalAccess), 32'd0);
    chk({tag, "_noreq2"}, 32'(dmemReq), 32'd0);
  endtask

  initial begin
    idle_exec();
    funct3_execute         = 3'b0;
    byteOffset_execute     = 2'b0;
    memAddress_execute     = 30'h0;
    memByteMask_execute    = 4'h0;
    memDataToWrite_execute = 32'h0;
    rdAddress_execute      = 5'h0;
    dmemReady              = 1'b0;
    dmemReadData           = 32'h0;

    // Reset state
    step();
    chk("rst_req", 32'(dmemReq), 32'd0);
    chk("rst_stall", 32'(memStall), 32'd0);
    chk("rst_wbvld", 32'(loadValid_writeback), 32'd0);
    chk("rst_wbres", loadResult_writeback, 32'd0);
    chk("rst_flags", 32'({misaligned, illegalAccess, busError}), 32'd0);
    reset = 1'b0;
    step();

    // 1: LW, zero-wait
    put(1'b1, 1'b0, 3'b010, 2'b00, 30'h100, 4'hF, 32'h0, 5'd5);
    dmemReady    = 1'b1;
    dmemReadData = 32'hDEADBEEF;
    #1;
    chk("lw_stall_idle", 32'(memStall), 32'd0);
    step();
    idle_exec();
    #1;
    chk("lw_req", 32'(dmemReq), 32'd1);
    chk("lw_addr", 32'(dmemAddress), 32'h100);
    chk("lw_we", 32'(dmemWriteEnable), 32'd0);
    chk("lw_stall", 32'(memStall), 32'd0);
    chk("lw_wb_early", 32'(loadValid_writeback), 32'd0);
    step();
    chk("lw_req_drop", 32'(dmemReq), 32'd0);
    chk("lw_vld", 32'(loadValid_writeback), 32'd1);
    chk("lw_res", loadResult_writeback, 32'hDEADBEEF);
    chk("lw_rd", 32'(rdAddress_writeback), 32'd5);
    step();
    chk("lw_vld_drop", 32'(loadValid_writeback), 32'd0);
    chk("lw_res_hold", loadResult_writeback, 32'hDEADBEEF);

    // 2: load extraction
    do_load("lb3",  3'b000, 2'd3, 32'h80FF1234, 32'hFFFFFF80);
    do_load("lbu3", 3'b100, 2'd3, 32'h80FF1234, 32'h00000080);
    do_load("lh2",  3'b001, 2'd2, 32'h80FF1234, 32'hFFFF80FF);
    do_load("lhu0", 3'b101, 2'd0, 32'h80FF1234, 32'h00001234);
    do_load("lb2",  3'b000, 2'd2, 32'h80FF1234, 32'hFFFFFFFF);
    do_load("lbu1", 3'b100, 2'd1, 32'h80FF1234, 32'h00000012);
    do_load("lhu2", 3'b101, 2'd2, 32'h80FF1234, 32'h000080FF);
    chk("ld_rd", 32'(rdAddress_writeback), 32'd9);

    // 3: SW with three wait cycles
    put(1'b0, 1'b1, 3'b010, 2'b00, 30'h2A, 4'hF, 32'h12345678, 5'd0);
    dmemReady = 1'b0;
    step();
    idle_exec();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_req", 32'(dmemReq), 32'd1);
      chk("sw_we", 32'(dmemWriteEnable), 32'd1);
      chk("sw_stall", 32'(memStall), 32'd1);
      chk("sw_wdata", dmemWriteData, 32'h12345678);
      step();
    end
    dmemReady = 1'b1;
    #1;
    chk("sw_stall_release", 32'(memStall), 32'd0);
    chk("sw_req_hold", 32'(dmemReq), 32'd1);
    step();
    chk("sw_done", 32'(dmemReq), 32'd0);
    chk("sw_no_wb", 32'(loadValid_writeback), 32'd0);

    // 4: back-to-back LW then SB
    put(1'b1, 1'b0, 3'b010, 2'b00, 30'h40, 4'hF, 32'h0, 5'd7);
    dmemReady    = 1'b1;
    dmemReadData = 32'hCAFEF00D;
    step();
    put(1'b0, 1'b1, 3'b000, 2'b10, 30'h41, 4'h4, 32'h00AB0000, 5'd0);
    #1;
    chk("b2b_req1", 32'(dmemReq), 32'd1);
    chk("b2b_addr1", 32'(dmemAddress), 32'h40);
    chk("b2b_mask1", 32'(dmemByteMask), 32'hF);
    chk("b2b_we1", 32'(dmemWriteEnable), 32'd0);
    step();
    idle_exec();
    #1;
    chk("b2b_req2", 32'(dmemReq), 32'd1);
    chk("b2b_addr2", 32'(dmemAddress), 32'h41);
    chk("b2b_mask2", 32'(dmemByteMask), 32'h4);
    chk("b2b_we2", 32'(dmemWriteEnable), 32'd1);
    chk("b2b_wbvld", 32'(loadValid_writeback), 32'd1);
    chk("b2b_wbres", loadResult_writeback, 32'hCAFEF00D);
    chk("b2b_wbrd", 32'(rdAddress_writeback), 32'd7);
    step();
    chk("b2b_idle", 32'(dmemReq), 32'd0);
    chk("b2b_no_wb", 32'(loadValid_writeback), 32'd0);

    // 5: rejected accesses
    reject("lh_off1", 1'b1, 1'b0, 3'b001, 2'b01, 1'b1, 1'b0);
    reject("sw_off2", 1'b0, 1'b1, 3'b010, 2'b10, 1'b1, 1'b0);
    reject("f3_011",  1'b1, 1'b0, 3'b011, 2'b00, 1'b0, 1'b1);
    reject("st_f3_4", 1'b0, 1'b1, 3'b100, 2'b00, 1'b0, 1'b1);
    reject("f3_111",  1'b1, 1'b0, 3'b111, 2'b11, 1'b0, 1'b1);

    // 6: watchdog abort with MAX_WAIT=4 (counter 0..4 across five REQ cycles)
    put(1'b1, 1'b0, 3'b010, 2'b00, 30'h55, 4'hF, 32'h0, 5'd2);
    dmemReady = 1'b0;
    step();
    idle_exec();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wd_req", 32'(dmemReq), 32'd1);
      chk("wd_stall", 32'(memStall), 32'd1);
      chk("wd_nobus", 32'(busError), 32'd0);
      step();
    end
    chk("wd_abort_req", 32'(dmemReq), 32'd0);
    chk("wd_abort_stall", 32'(memStall), 32'd0);
    chk("wd_buserr", 32'(busError), 32'd1);
    chk("wd_no_wb", 32'(loadValid_writeback), 32'd0);
    step();
    chk("wd_buserr_end", 32'(busError), 32'd0);
    chk("wd_idle", 32'(dmemReq), 32'd0);

    // 6b: asynchronous reset mid-request
    put(1'b1, 1'b0, 3'b010, 2'b00, 30'h77, 4'hF, 32'h0, 5'd4);
    step();
    idle_exec();
    #1;
    chk("ar_req_before", 32'(dmemReq), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_req", 32'(dmemReq), 32'd0);
    chk("ar_stall", 32'(memStall), 32'd0);
    chk("ar_wbres", loadResult_writeback, 32'd0);
    chk("ar_addr", 32'(dmemAddress), 32'd0);
    reset = 1'b0;
    step();
    chk("ar_after", 32'(dmemReq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
